// File: rtl/jtframe_dwnld_writer.sv
// ROM download writer: decodes loader byte addresses into SDRAM bank/word/lane,
// buffers them in a small FIFO and issues handshaked prog writes.
module jtframe_dwnld_writer #(
  parameter logic [24:0] BA1_START = 25'h040_0000,
  parameter logic [24:0] BA2_START = 25'h080_0000,
  parameter logic [24:0] BA3_START = 25'h0C0_0000,
  parameter logic        SWAB      = 1'b0,
  parameter int          TAIL      = 16
) (
  input  logic        clk_rom,
  input  logic        rst,
  input  logic        downloading,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_data,
  input  logic        ioctl_wr,
  input  logic        prog_rdy,
  output logic [21:0] prog_addr,
  output logic [7:0]  prog_data,
  output logic [1:0]  prog_mask,
  output logic [1:0]  prog_bank,
  output logic        prog_we,
  output logic        dwnld_busy,
  output logic        overflow
);

  localparam int CW = (TAIL > 1) ? $clog2(TAIL) : 1;

  typedef struct packed {
    logic [1:0]  bank;
    logic [21:0] addr;
    logic [1:0]  mask;
    logic [7:0]  data;
  } entry_t;

  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_TAIL} state_t;

  state_t      r_state, w_state_next;
  entry_t      r_fifo [4];
  logic [1:0]  r_wr_ptr, r_rd_ptr;
  logic [2:0]  r_count;
  logic [CW-1:0] r_tail_cnt, w_tail_cnt_next;
  logic        r_dl_d, r_was_dl, r_overflow;
  logic        r_prog_we, w_prog_we_next;
  entry_t      r_prog, w_prog_next;

  logic [1:0]  w_bank;
  logic [24:0] w_start;
  logic [22:0] w_offset;
  entry_t      w_entry, w_head;
  logic        w_push_req, w_full, w_pop, w_push, w_dl_rise, w_enter_tail;

  always_comb begin
    w_bank  = 2'd3;
    w_start = BA3_START;
    if (ioctl_addr < BA1_START) begin
      w_bank  = 2'd0;
      w_start = '0;
    end else if (ioctl_addr < BA2_START) begin
      w_bank  = 2'd1;
      w_start = BA1_START;
    end else if (ioctl_addr < BA3_START) begin
      w_bank  = 2'd2;
      w_start = BA2_START;
    end
  end

  // Only 23 offset bits matter: word address is offset[22:1], lane is offset[0].
  assign w_offset     = 23'(ioctl_addr - w_start);
  assign w_entry.bank = w_bank;
  assign w_entry.addr = w_offset[22:1];
  assign w_entry.mask = (w_offset[0] ^ SWAB) ? 2'b01 : 2'b10;
  assign w_entry.data = ioctl_data;

  assign w_head     = r_fifo[r_rd_ptr];
  assign w_dl_rise  = downloading & ~r_dl_d;
  assign w_push_req = ioctl_wr & downloading;
  assign w_full     = (r_count == 3'd4);
  // The head leaves the FIFO when it is loaded onto prog_*, freeing its slot.
  assign w_pop      = (r_state == ST_IDLE) && (r_count != 3'd0);
  assign w_push     = w_push_req & (~w_full | w_pop);

  always_ff @(posedge clk_rom) begin
    if (w_push) r_fifo[r_wr_ptr] <= w_entry;
  end

  always_ff @(posedge clk_rom or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_dl_d     <= 1'b0;
      r_was_dl   <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_dl_d <= downloading;
      if (w_push) r_wr_ptr <= r_wr_ptr + 2'd1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 2'd1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
      if (downloading)       r_was_dl <= 1'b1;
      else if (w_enter_tail) r_was_dl <= 1'b0;
      if (w_push_req && w_full && !w_pop) r_overflow <= 1'b1;
      else if (w_dl_rise)                 r_overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk_rom or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_tail_cnt <= '0;
      r_prog_we  <= 1'b0;
      r_prog     <= '{bank: 2'd0, addr: 22'd0, mask: 2'b11, data: 8'd0};
    end else begin
      r_state    <= w_state_next;
      r_tail_cnt <= w_tail_cnt_next;
      r_prog_we  <= w_prog_we_next;
      r_prog     <= w_prog_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_tail_cnt_next = r_tail_cnt;
    w_prog_we_next  = r_prog_we;
    w_prog_next     = r_prog;
    w_enter_tail    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_count != 3'd0) begin
          w_prog_next    = w_head;
          w_prog_we_next = 1'b1;
          w_state_next   = ST_WRITE;
        end else if (!downloading && r_was_dl) begin
          w_enter_tail = 1'b1;
        end
      end
      ST_WRITE: begin
        if (prog_rdy) begin
          w_prog_we_next = 1'b0;
          // Going straight to TAIL keeps busy continuous after the final write.
          if (r_count == 3'd0 && !downloading && r_was_dl) w_enter_tail = 1'b1;
          else                                             w_state_next = ST_IDLE;
        end
      end
      ST_TAIL: begin
        if (w_dl_rise || r_tail_cnt == '0) w_state_next = ST_IDLE;
        else                               w_tail_cnt_next = r_tail_cnt - 1'b1;
      end
      default: w_state_next = ST_IDLE;
    endcase
    if (w_enter_tail) begin
      w_state_next    = ST_TAIL;
      w_tail_cnt_next = CW'(TAIL - 1);
    end
  end

  assign prog_addr  = r_prog.addr;
  assign prog_data  = r_prog.data;
  assign prog_mask  = r_prog.mask;
  assign prog_bank  = r_prog.bank;
  assign prog_we    = r_prog_we;
  assign overflow   = r_overflow;
  assign dwnld_busy = downloading || (r_count != 3'd0) ||
                      (r_state == ST_WRITE) || (r_state == ST_TAIL);

endmodule

// File: tb/tb_jtframe_dwnld_writer.sv
// Directed bench for jtframe_dwnld_writer: decode table, FIFO overflow,
// drain-then-tail timing and asynchronous reset mid-write.
module tb_jtframe_dwnld_writer;

  logic        clk = 1'b0;
  logic        rst, downloading, ioctl_wr, prog_rdy;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_data;
  logic [21:0] prog_addr, s_prog_addr;
  logic [7:0]  prog_data, s_prog_data;
  logic [1:0]  prog_mask, s_prog_mask, prog_bank, s_prog_bank;
  logic        prog_we, s_prog_we, dwnld_busy, s_dwnld_busy, overflow, s_overflow;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  jtframe_dwnld_writer dut (
    .clk_rom(clk), .rst(rst), .downloading(downloading),
    .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr),
    .prog_rdy(prog_rdy), .prog_addr(prog_addr), .prog_data(prog_data),
    .prog_mask(prog_mask), .prog_bank(prog_bank), .prog_we(prog_we),
    .dwnld_busy(dwnld_busy), .overflow(overflow)
  );

  jtframe_dwnld_writer #(.SWAB(1'b1)) dut_swab (
    .clk_rom(clk), .rst(rst), .downloading(downloading),
    .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr),
    .prog_rdy(prog_rdy), .prog_addr(s_prog_addr), .prog_data(s_prog_data),
    .prog_mask(s_prog_mask), .prog_bank(s_prog_bank), .prog_we(s_prog_we),
    .dwnld_busy(s_dwnld_busy), .overflow(s_overflow)
  );

  typedef struct {
    logic [24:0] addr;
    logic [7:0]  data;
    logic [1:0]  bank;
    logic [21:0] paddr;
    logic [1:0]  mask;
    logic [1:0]  mask_swab;
  } vec_t;

  vec_t vecs [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_we(input string name);
    int n = 0;
    while (!prog_we && n < 20) begin
      tick();
      n++;
    end
    check(name, {31'd0, prog_we}, 32'd1);
  endtask

  task automatic push(input logic [24:0] a, input logic [7:0] d);
    ioctl_addr = a;
    ioctl_data = d;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr   = 1'b0;
  endtask

  initial begin
    int n;
    vecs[0] = '{25'h000_0005, 8'hA5, 2'd0, 22'h000002, 2'b01, 2'b10};
    vecs[1] = '{25'h040_0002, 8'h11, 2'd1, 22'h000001, 2'b10, 2'b01};
    vecs[2] = '{25'h0C0_0011, 8'h22, 2'd3, 22'h000008, 2'b01, 2'b10};
    vecs[3] = '{25'h080_0003, 8'h33, 2'd2, 22'h000001, 2'b01, 2'b10};
    vecs[4] = '{25'h03F_FFFF, 8'h44, 2'd0, 22'h1FFFFF, 2'b01, 2'b10};
    vecs[5] = '{25'h040_0000, 8'h55, 2'd1, 22'h000000, 2'b10, 2'b01};
    vecs[6] = '{25'h0FF_FFFE, 8'h66, 2'd3, 22'h1FFFFF, 2'b10, 2'b01};
    vecs[7] = '{25'h1FF_FFFF, 8'h77, 2'd3, 22'h1FFFFF, 2'b01, 2'b10};

    rst = 1'b1; downloading = 1'b0; ioctl_wr = 1'b0; prog_rdy = 1'b0;
    ioctl_addr = '0; ioctl_data = '0;
    tick(); tick();
    check("rst_we",   {31'd0, prog_we}, 32'd0);
    check("rst_addr", {10'd0, prog_addr}, 32'd0);
    check("rst_data", {24'd0, prog_data}, 32'd0);
    check("rst_mask", {30'd0, prog_mask}, 32'd3);
    check("rst_bank", {30'd0, prog_bank}, 32'd0);
    check("rst_busy", {31'd0, dwnld_busy}, 32'd0);
    check("rst_ovf",  {31'd0, overflow}, 32'd0);
    rst = 1'b0;
    tick();

    // Writes outside a download are ignored.
    push(25'h000_0010, 8'hEE);
    for (int k = 0; k < 3; k++) begin
      check("ignored_we", {31'd0, prog_we}, 32'd0);
      tick();
    end
    check("ignored_busy", {31'd0, dwnld_busy}, 32'd0);

    downloading = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      push(vecs[i].addr, vecs[i].data);
      check("lat0_we", {31'd0, prog_we}, 32'd0);
      tick();
      check("lat1_we", {31'd0, prog_we}, 32'd1);
      check("bank", {30'd0, prog_bank}, {30'd0, vecs[i].bank});
      check("addr", {10'd0, prog_addr}, {10'd0, vecs[i].paddr});
      check("mask", {30'd0, prog_mask}, {30'd0, vecs[i].mask});
      check("data", {24'd0, prog_data}, {24'd0, vecs[i].data});
      check("swab_mask", {30'd0, s_prog_mask}, {30'd0, vecs[i].mask_swab});
      $display("vec %0d addr %h bank %0d paddr %h mask %b swab_mask %b data %h",
               i, vecs[i].addr, prog_bank, prog_addr, prog_mask, s_prog_mask, prog_data);
      for (int k = 0; k < 2; k++) begin
        tick();
        check("hold_we", {31'd0, prog_we}, 32'd1);
        check("hold_addr", {10'd0, prog_addr}, {10'd0, vecs[i].paddr});
      end
      prog_rdy = 1'b1;
      tick();
      prog_rdy = 1'b0;
      check("rdy_drop_we", {31'd0, prog_we}, 32'd0);
      tick();
      check("no_reissue_we", {31'd0, prog_we}, 32'd0);
    end

    // Six back-to-back bytes with prog_rdy low: one in flight, four queued, one dropped.
    for (int i = 0; i < 6; i++) push(25'h000_0100 + 25'(i), 8'hC0 + 8'(i));
    check("ovf_head", {24'd0, prog_data}, 32'hC0);
    check("ovf_set", {31'd0, overflow}, 32'd1);
    $display("overflow burst: head %h overflow %0d", prog_data, overflow);
    for (int j = 1; j <= 4; j++) begin
      prog_rdy = 1'b1;
      tick();
      prog_rdy = 1'b0;
      check("b2b_gap", {31'd0, prog_we}, 32'd0);
      wait_we("ovf_drain_wait");
      check("ovf_drain_data", {24'd0, prog_data}, 32'hC0 + 32'(j));
      $display("drain %0d data %h", j, prog_data);
    end
    prog_rdy = 1'b1;
    tick();
    prog_rdy = 1'b0;
    tick(); tick(); tick();
    check("sixth_dropped", {31'd0, prog_we}, 32'd0);
    check("ovf_sticky", {31'd0, overflow}, 32'd1);

    // Leave the download, then restart it: the tail is aborted and overflow cleared.
    downloading = 1'b0;
    tick();
    check("ovf_after_fall", {31'd0, overflow}, 32'd1);
    check("tail_busy", {31'd0, dwnld_busy}, 32'd1);
    downloading = 1'b1;
    tick();
    check("ovf_cleared", {31'd0, overflow}, 32'd0);

    // Three queued writes then download ends: drain in order, then a 16-cycle tail.
    for (int i = 0; i < 3; i++) push(25'h040_0010 + 25'(i), 8'hD0 + 8'(i));
    downloading = 1'b0;
    for (int j = 0; j < 3; j++) begin
      wait_we("tail_drain_wait");
      check("tail_drain_data", {24'd0, prog_data}, 32'hD0 + 32'(j));
      check("tail_drain_busy", {31'd0, dwnld_busy}, 32'd1);
      $display("tail drain %0d data %h", j, prog_data);
      prog_rdy = 1'b1;
      tick();
      prog_rdy = 1'b0;
    end
    n = 0;
    while (dwnld_busy && n < 40) begin
      n++;
      tick();
    end
    check("tail_len", 32'(n), 32'd16);
    $display("tail busy cycles %0d", n);
    tick(); tick();
    check("after_tail_we", {31'd0, prog_we}, 32'd0);
    check("after_tail_busy", {31'd0, dwnld_busy}, 32'd0);

    // Asynchronous reset while a write is pending.
    downloading = 1'b1;
    push(25'h000_0005, 8'h5A);
    push(25'h000_0006, 8'h5B);
    check("pre_rst_we", {31'd0, prog_we}, 32'd1);
    downloading = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("async_rst_we", {31'd0, prog_we}, 32'd0);
    check("async_rst_busy", {31'd0, dwnld_busy}, 32'd0);
    check("async_rst_mask", {30'd0, prog_mask}, 32'd3);
    $display("reset mid-write: prog_we %0d busy %0d", prog_we, dwnld_busy);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("post_rst_we", {31'd0, prog_we}, 32'd0);
    end
    check("post_rst_busy", {31'd0, dwnld_busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
